// File: rtl/mul_add_seq_if.sv
// Request/response bundle for the sequential multiply-accumulate unit.
// Same start/valid handshake as the sequential divider.
interface mul_add_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             valid;

    modport master (
        output start, multiplicand, multiplier, addend,
        input  result, overflow, valid
    );

    modport slave (
        input  start, multiplicand, multiplier, addend,
        output result, overflow, valid
    );
endinterface

// File: rtl/mul_add_seq.sv
// Sequential shift-add multiply-accumulate: result = A*B + C (unsigned).
// One multiplier bit per clock, LSB first; a repeat of the last completed
// operand set can be answered from the held accumulator.
module mul_add_seq #(
    parameter int WIDTH    = 32,
    parameter bit CACHING  = 1'b1,
    parameter bit INIT_VLD = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    mul_add_seq_if.slave bus
);
    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY,
        S_HIT,
        S_FIN,
        S_DONE
    } state_t;

    state_t           state, nstate;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    sh_a;
    logic [CW-1:0]    cnt;
    logic             cache_vld;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic             valid_q;

    logic             accept;
    logic             hit;
    logic             match;
    logic             last;

    assign match = (bus.multiplicand == a_q) &&
                   (bus.multiplier   == b_q) &&
                   (bus.addend       == c_q);
    assign last  = (cnt == CNT_LAST);

    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
    assign bus.valid    = valid_q;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nstate;
    end

    // next state; start only counts in IDLE/DONE, a cache hit detours through HIT
    // so the reply still lands two edges after the accepting edge
    always_comb begin
        nstate = state;
        accept = 1'b0;
        hit    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    hit    = CACHING && cache_vld && match;
                    nstate = hit ? S_HIT : S_BUSY;
                end
            end
            S_BUSY:  if (last) nstate = S_FIN;
            S_HIT:   nstate = S_FIN;
            S_FIN:   nstate = S_DONE;
            default: nstate = S_IDLE;
        endcase
    end

    // operand latch; doubles as the cache tag, only trusted while cache_vld is set
    always_ff @(posedge clk) begin
        if (accept && !hit) begin
            a_q <= bus.multiplicand;
            b_q <= bus.multiplier;
            c_q <= bus.addend;
        end
    end

    // accumulator seeded with C, plus A shifted left once per consumed multiplier bit;
    // left untouched on a cache hit so FIN republishes the previous answer
    always_ff @(posedge clk) begin
        if (accept && !hit) begin
            acc  <= {{(AW - WIDTH){1'b0}}, bus.addend};
            sh_a <= {{(AW - WIDTH){1'b0}}, bus.multiplicand};
        end else if (state == S_BUSY) begin
            if (b_q[cnt]) acc <= acc + sh_a;
            sh_a <= sh_a << 1;
        end
    end

    // multiplier bit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cnt <= '0;
        else if (accept)          cnt <= '0;
        else if (state == S_BUSY) cnt <= cnt + CW'(1);
    end

    // cache flag: set when a full op finishes, dropped when new operands are taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          cache_vld <= 1'b0;
        else if (state == S_BUSY && last) cache_vld <= 1'b1;
        else if (accept && !hit)          cache_vld <= 1'b0;
    end

    // published result; holds across BUSY, only valid drops on the accepting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= INIT_VLD;
        end else if (accept) begin
            valid_q  <= 1'b0;
        end else if (state == S_FIN) begin
            result_q <= acc[WIDTH-1:0];
            ovf_q    <= |acc[AW-1:WIDTH];
            valid_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mul_add_seq.sv
// Directed bench for mul_add_seq (WIDTH=32, CACHING=1, INIT_VLD=0).
module tb_mul_add_seq;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    mul_add_seq_if #(.WIDTH(32)) bus ();

    mul_add_seq #(.WIDTH(32), .CACHING(1'b1), .INIT_VLD(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // one-cycle start pulse; returns #1 after the accepting edge
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(negedge clk);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.addend       = c;
        bus.start        = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // edges until valid rises, -1 if it never does within 40 edges
    task automatic measure(output int lat);
        int k;
        k   = 0;
        lat = -1;
        while (lat < 0 && k < 40) begin
            k++;
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) lat = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        bus.addend = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.result); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", bus.valid); end
    endtask

    task automatic test_zero_mult();
        int lat;
        launch(32'h20000001, 32'h0, 32'h10000001);
        measure(lat);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL zb_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.result !== 32'h10000001) begin n_bad++; $display("FAIL zb_result: got %h want 10000001", bus.result); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL zb_ovf: got %b want 0", bus.overflow); end
        launch(32'h0, 32'h12345678, 32'hCAFEF00D);
        measure(lat);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL za_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.result !== 32'hCAFEF00D) begin n_bad++; $display("FAIL za_result: got %h want cafef00d", bus.result); end
    endtask

    task automatic test_basic();
        int lat;
        launch(32'd7, 32'd6, 32'd5);
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL basic_drop: got %b want 0", bus.valid); end
        n_cmp++; if (bus.result !== 32'hCAFEF00D) begin n_bad++; $display("FAIL basic_hold: got %h want cafef00d", bus.result); end
        measure(lat);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL basic_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.result !== 32'h0000002F) begin n_bad++; $display("FAIL basic_result: got %h want 0000002f", bus.result); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", bus.overflow); end
    endtask

    task automatic test_cache();
        int lat;
        launch(32'd7, 32'd6, 32'd5);
        measure(lat);
        n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL cache_latency: got %0d want 2", lat); end
        n_cmp++; if (bus.result !== 32'h0000002F) begin n_bad++; $display("FAIL cache_result: got %h want 0000002f", bus.result); end
        launch(32'd7, 32'd6, 32'd6);
        measure(lat);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL miss_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.result !== 32'h00000030) begin n_bad++; $display("FAIL miss_result: got %h want 00000030", bus.result); end
    endtask

    task automatic test_overflow();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] vc [5];
        logic [31:0] vr [5];
        logic        vo [5];
        int          lat;
        va[0] = 32'h00010000; vb[0] = 32'h00010000; vc[0] = 32'h0;        vr[0] = 32'h0;        vo[0] = 1'b1;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; vc[1] = 32'hFFFFFFFF; vr[1] = 32'h0;        vo[1] = 1'b1;
        va[2] = 32'h80000000; vb[2] = 32'h1;        vc[2] = 32'h7FFFFFFF; vr[2] = 32'hFFFFFFFF; vo[2] = 1'b0;
        va[3] = 32'h0000FFFF; vb[3] = 32'h00010001; vc[3] = 32'h12345678; vr[3] = 32'h12345677; vo[3] = 1'b1;
        va[4] = 32'h3;        vb[4] = 32'h80000000; vc[4] = 32'h0;        vr[4] = 32'h80000000; vo[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            launch(va[i], vb[i], vc[i]);
            measure(lat);
            n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL ovf%0d_latency: got %0d want 33", i, lat); end
            n_cmp++; if (bus.result !== vr[i]) begin n_bad++; $display("FAIL ovf%0d_result: got %h want %h", i, bus.result, vr[i]); end
            n_cmp++; if (bus.overflow !== vo[i]) begin n_bad++; $display("FAIL ovf%0d_flag: got %b want %b", i, bus.overflow, vo[i]); end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        launch(32'd3, 32'd4, 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.multiplicand = 32'd100;
        bus.multiplier   = 32'd100;
        bus.addend       = 32'd100;
        bus.start        = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        measure(lat);
        n_cmp++; if (lat != 22) begin n_bad++; $display("FAIL ign_latency: got %0d more edges want 22", lat); end
        n_cmp++; if (bus.result !== 32'h0000000D) begin n_bad++; $display("FAIL ign_result: got %h want 0000000d", bus.result); end
    endtask

    task automatic test_rst_abort();
        int lat;
        launch(32'd9, 32'd9, 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", bus.valid); end
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL abort_result: got %h want 0", bus.result); end
        @(negedge clk) rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++; if (bus.valid !== 1'b0 || bus.result !== 32'h0) begin n_bad++; $display("FAIL abort_partial: got valid %b result %h want 0/0", bus.valid, bus.result); end
        launch(32'd9, 32'd9, 32'd0);
        measure(lat);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL abort_rerun_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.result !== 32'h00000051) begin n_bad++; $display("FAIL abort_rerun_result: got %h want 00000051", bus.result); end
        // completed op is now cached; a reset must forget it
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        launch(32'd9, 32'd9, 32'd0);
        measure(lat);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL cache_clear_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.result !== 32'h00000051) begin n_bad++; $display("FAIL cache_clear_result: got %h want 00000051", bus.result); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        bus.multiplicand = 32'd2;
        bus.multiplier   = 32'd3;
        bus.addend       = 32'd4;
        bus.start        = 1'b1;
        @(posedge clk);
        measure(lat);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL held_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.result !== 32'h0000000A) begin n_bad++; $display("FAIL held_result: got %h want 0000000a", bus.result); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL held_reaccept: got valid %b want 0", bus.valid); end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL held_hit_wait: got valid %b want 0", bus.valid); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.valid !== 1'b1 || bus.result !== 32'h0000000A) begin n_bad++; $display("FAIL held_hit_done: got valid %b result %h want 1/0000000a", bus.valid, bus.result); end
    endtask

    task automatic test_start_on_release();
        int lat;
        @(negedge clk);
        rst              = 1'b1;
        bus.multiplicand = 32'd1;
        bus.multiplier   = 32'd1;
        bus.addend       = 32'd1;
        bus.start        = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL release_accept: got valid %b want 0", bus.valid); end
        measure(lat);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL release_latency: got %0d want 33", lat); end
        n_cmp++; if (bus.result !== 32'h00000002) begin n_bad++; $display("FAIL release_result: got %h want 00000002", bus.result); end
    endtask

    initial begin
        test_reset();
        test_zero_mult();
        test_basic();
        test_cache();
        test_overflow();
        test_ignore_start();
        test_rst_abort();
        test_back_to_back();
        test_start_on_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
